// File: rtl/microwave_time_entry.sv
// Microwave keypad front end: shifts digits into an M:SS cook-time preset and
// hands it to the countdown timer with a one-cycle load strobe on START.
module microwave_time_entry #(
    parameter int QUICK_START_TENS = 3,
    parameter int MAX_DIGITS       = 3
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       timer_busy,
    input  logic       timer_done,
    output logic       load,
    output logic [3:0] minutes_units,
    output logic [2:0] seconds_tens,
    output logic [3:0] seconds_units,
    output logic [1:0] digit_count,
    output logic       armed,
    output logic       key_error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_ARMED = 2'd2
    } state_t;

    localparam logic [3:0] KEY_START = 4'd10;
    localparam logic [3:0] KEY_CLEAR = 4'd11;

    state_t     r_state;
    logic [3:0] r_min_units;
    logic [2:0] r_sec_tens;
    logic [3:0] r_sec_units;
    logic [1:0] r_digit_count;
    logic       r_load;
    logic       r_armed;
    logic       r_key_error;

    state_t     w_state_next;
    logic [3:0] w_min_units_next;
    logic [2:0] w_sec_tens_next;
    logic [3:0] w_sec_units_next;
    logic [1:0] w_digit_count_next;
    logic       w_load_next;
    logic       w_key_error_next;

    logic       w_is_digit;
    logic       w_is_start;
    logic       w_is_clear;
    logic       w_preset_zero;
    logic       w_digit_reject;

    assign w_is_digit    = key_valid && (key_code <= 4'd9);
    assign w_is_start    = key_valid && (key_code == KEY_START);
    assign w_is_clear    = key_valid && (key_code == KEY_CLEAR);
    assign w_preset_zero = (r_min_units == 4'd0) && (r_sec_tens == 3'd0) && (r_sec_units == 4'd0);
    // A units digit above 5 would become an illegal seconds-tens after the shift.
    assign w_digit_reject = (r_digit_count == 2'(MAX_DIGITS)) || (r_sec_units > 4'd5);

    always_comb begin
        w_state_next       = r_state;
        w_min_units_next   = r_min_units;
        w_sec_tens_next    = r_sec_tens;
        w_sec_units_next   = r_sec_units;
        w_digit_count_next = r_digit_count;
        w_load_next        = 1'b0;
        w_key_error_next   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_is_digit) begin
                    w_min_units_next   = {1'b0, r_sec_tens};
                    w_sec_tens_next    = r_sec_units[2:0];
                    w_sec_units_next   = key_code;
                    w_digit_count_next = r_digit_count + 2'd1;
                    w_state_next       = S_ENTRY;
                end else if (w_is_start) begin
                    if (timer_busy) begin
                        w_key_error_next = 1'b1;
                    end else begin
                        w_min_units_next = 4'd0;
                        w_sec_tens_next  = 3'(QUICK_START_TENS);
                        w_sec_units_next = 4'd0;
                        w_load_next      = 1'b1;
                        w_state_next     = S_ARMED;
                    end
                end
            end
            S_ENTRY: begin
                if (w_is_digit) begin
                    if (w_digit_reject) begin
                        w_key_error_next = 1'b1;
                    end else begin
                        w_min_units_next   = {1'b0, r_sec_tens};
                        w_sec_tens_next    = r_sec_units[2:0];
                        w_sec_units_next   = key_code;
                        w_digit_count_next = r_digit_count + 2'd1;
                    end
                end else if (w_is_start) begin
                    if (timer_busy || w_preset_zero) begin
                        w_key_error_next = 1'b1;
                    end else begin
                        w_load_next  = 1'b1;
                        w_state_next = S_ARMED;
                    end
                end else if (w_is_clear) begin
                    w_min_units_next   = 4'd0;
                    w_sec_tens_next    = 3'd0;
                    w_sec_units_next   = 4'd0;
                    w_digit_count_next = 2'd0;
                    w_state_next       = S_IDLE;
                end
            end
            S_ARMED: begin
                // timer_done takes priority so a simultaneous key never flags an error.
                if (timer_done || w_is_clear) begin
                    w_min_units_next   = 4'd0;
                    w_sec_tens_next    = 3'd0;
                    w_sec_units_next   = 4'd0;
                    w_digit_count_next = 2'd0;
                    w_state_next       = S_IDLE;
                end else if (w_is_digit || w_is_start) begin
                    w_key_error_next = 1'b1;
                end
            end
            default: begin
                w_min_units_next   = 4'd0;
                w_sec_tens_next    = 3'd0;
                w_sec_units_next   = 4'd0;
                w_digit_count_next = 2'd0;
                w_state_next       = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state       <= S_IDLE;
            r_min_units   <= 4'd0;
            r_sec_tens    <= 3'd0;
            r_sec_units   <= 4'd0;
            r_digit_count <= 2'd0;
            r_load        <= 1'b0;
            r_armed       <= 1'b0;
            r_key_error   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_min_units   <= w_min_units_next;
            r_sec_tens    <= w_sec_tens_next;
            r_sec_units   <= w_sec_units_next;
            r_digit_count <= w_digit_count_next;
            r_load        <= w_load_next;
            r_armed       <= (w_state_next == S_ARMED);
            r_key_error   <= w_key_error_next;
        end
    end

    assign load          = r_load;
    assign minutes_units = r_min_units;
    assign seconds_tens  = r_sec_tens;
    assign seconds_units = r_sec_units;
    assign digit_count   = r_digit_count;
    assign armed         = r_armed;
    assign key_error     = r_key_error;

endmodule

// File: doc/microwave_time_entry.md
Name: microwave_time_entry

Overview:
Keypad front end that builds the cook-time preset (M:SS, 0:00–9:59) for the minutes/seconds countdown timer. Digits shift in from the right, microwave-style. On START, the block presents the BCD preset and issues a one-cycle load strobe to the timer. It then holds in ARMED until the timer reports done or the user clears.

Parameters:
QUICK_START_TENS, 3, seconds-tens value loaded when START is pressed with no digits entered (quick-start 0:30)
MAX_DIGITS, 3, number of digits accepted before further digits are rejected (fixed by M:SS format)

Ports:
CLK  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising CLK)
key_valid  input  1  one-cycle strobe, key_code valid this cycle
key_code  input  4  0–9 digit, 10 START, 11 CLEAR, 12–15 ignored
timer_busy  input  1  high while timer is counting
timer_done  input  1  one-cycle pulse when timer reaches 0:00
load  output  1  one-cycle strobe: timer samples preset outputs this cycle
minutes_units  output  4  preset minutes BCD 0–9
seconds_tens  output  3  preset seconds tens 0–5
seconds_units  output  4  preset seconds units 0–9
digit_count  output  2  digits accepted so far, 0–3
armed  output  1  high in ARMED state
key_error  output  1  one-cycle pulse on rejected key

Behaviour:
- Reset (Reset=0 at rising edge): state IDLE; minutes_units=0, seconds_tens=0, seconds_units=0, digit_count=0, load=0, armed=0, key_error=0. Reset wins over every other input, in any state.
- All outputs are registered. A key accepted at edge N is visible in the outputs after edge N. No combinational path from inputs to outputs.
- Keys are processed only when key_valid=1. key_code 12–15 is ignored silently, with no error pulse.
- State IDLE (digit_count=0):
  - digit d → shift, state ENTRY.
  - START → quick-start: load preset 0:QUICK_START_TENS:0, pulse load, state ARMED.
  - CLEAR → no-op.
- Shift on digit d: minutes_units←seconds_tens (zero-extended), seconds_tens←seconds_units[2:0], seconds_units←d, digit_count++.
- State ENTRY:
  - Digit reject rule: reject (key_error=1, no change) if digit_count==MAX_DIGITS, or if seconds_units>5 (the shift would make tens>5).
  - START with preset≠0:00 → load=1 for exactly one cycle, state ARMED, preset frozen.
  - START with preset==0:00 (e.g. digits "0","0") → key_error, stay ENTRY.
  - CLEAR → zero preset and digit_count, state IDLE.
- State ARMED (armed=1):
  - Digits and START → key_error, no change.
  - CLEAR → zero everything, state IDLE. Timer stop is owned by the top level via the armed fall.
  - timer_done=1 → zero preset and digit_count, state IDLE.
  - timer_done and CLEAR in the same cycle → state IDLE, one transition, no error.
- START while timer_busy=1 (any state) → key_error, no load. A load never issues into a busy timer.
- load is high only on the cycle after the START edge and is never high for two consecutive cycles.
- Preset outputs are stable from the load cycle until leaving ARMED.

Test Plan:
- Reset=0 for 2 cycles with random keys → all outputs 0, state IDLE; release, key 5 → seconds_units=5, digit_count=1.
- Keys 1,3,0 then START → preset 1:30 (minutes_units=1, seconds_tens=3, seconds_units=0), load=1 for exactly one cycle, armed=1; timer_done pulse → all zero, armed=0.
- Key 7 then 2 → second digit rejected (7>5), key_error one pulse, preset 0:07 retained; keys 4,5,9 then 1 → fourth digit rejected, preset 4:59.
- START in IDLE with timer_busy=0 → preset 0:30, load pulse; repeat with timer_busy=1 → key_error, no load, state IDLE.
- Keys 0,0 then START → key_error, no load; CLEAR → IDLE, digit_count=0.
- Mid-ARMED: digit 8 → key_error, preset unchanged; Reset=0 asserted on the same edge as timer_done → reset values, no load.
